lsu_master: RTL

//  Load/store initiator that drives the word-wide data-memory port (Ad/Data/r/w/Out) on behalf of the MEM stage.

---
 rtl/lsu_master.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/lsu_master.sv
// Load/store initiator for the word-wide data memory port.
// One RV32I load/store at a time; sub-word stores are done as read-modify-write.
module lsu_master #(
   parameter int n = 5
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_we,
   input  logic [2:0]    req_funct3,
   input  logic [31:0]   req_addr,
   input  logic [31:0]   req_wdata,
   output logic          rsp_valid,
   output logic          rsp_err,
   output logic [31:0]   rsp_rdata,
   output logic          busy,
   output logic [n-1:0]  mem_ad,
   output logic [31:0]   mem_data,
   output logic          mem_r,
   output logic          mem_w,
   input  logic [31:0]   mem_out
);

   // state  | meaning
   // IDLE   | waiting for a request, req_ready=1
   // RD     | read strobe for load or sub-word store
   // WAIT   | memory returns the word; extract load data or merge store data
   // WR     | write strobe with final word
   // RESP   | completion pulse, no error
   // ERR    | completion pulse with error, no memory access
   typedef enum logic [2:0] {
      S_IDLE, S_RD, S_WAIT, S_WR, S_RESP, S_ERR
   } state_t;

   state_t        state_q, state_d;
   logic          we_q, we_d;
   logic [2:0]    f3_q, f3_d;
   logic [1:0]    off_q, off_d;
   logic [n-1:0]  idx_q, idx_d;
   logic [31:0]   data_q, data_d;
   logic [31:0]   rdata_q, rdata_d;

   logic          accept;
   logic          f3_ok;
   logic          misaligned;
   logic          req_legal;
   logic [7:0]    lane_b;
   logic [15:0]   lane_h;
   logic [31:0]   load_ext;
   logic [31:0]   merged;
   logic          unused_addr;

   assign unused_addr = ^req_addr[31:n+2];
   assign accept      = req_valid & req_ready;

   always_comb begin
      f3_ok = 1'b0;
      case (req_funct3)
         3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
         3'b100, 3'b101:         f3_ok = ~req_we;
         default:                f3_ok = 1'b0;
      endcase
      misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
      req_legal  = f3_ok & ~misaligned;
   end

   always_comb begin
      lane_b = mem_out[{off_q, 3'b000} +: 8];
      lane_h = off_q[1] ? mem_out[31:16] : mem_out[15:0];
      case (f3_q)
         3'b000:  load_ext = {{24{lane_b[7]}}, lane_b};
         3'b001:  load_ext = {{16{lane_h[15]}}, lane_h};
         3'b100:  load_ext = {24'b0, lane_b};
         3'b101:  load_ext = {16'b0, lane_h};
         default: load_ext = mem_out;
      endcase
   end

   // Store data sits in data_q until the read returns; merge it into the fetched word.
   always_comb begin
      merged = mem_out;
      case (f3_q[1:0])
         2'b00: merged[{off_q, 3'b000} +: 8] = data_q[7:0];
         2'b01: begin
            if (off_q[1]) merged[31:16] = data_q[15:0];
            else          merged[15:0]  = data_q[15:0];
         end
         default: merged = data_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         we_q    <= 1'b0;
         f3_q    <= 3'b000;
         off_q   <= 2'b00;
         idx_q   <= '0;
         data_q  <= 32'b0;
         rdata_q <= 32'b0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         f3_q    <= f3_d;
         off_q   <= off_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         rdata_q <= rdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      f3_d    = f3_q;
      off_d   = off_q;
      idx_d   = idx_q;
      data_d  = data_q;
      rdata_d = rdata_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               we_d   = req_we;
               f3_d   = req_funct3;
               off_d  = req_addr[1:0];
               idx_d  = req_addr[n+1:2];
               data_d = req_wdata;
               if (!req_legal) begin
                  rdata_d = 32'b0;
                  state_d = S_ERR;
               end else if (!req_we || (req_funct3[1:0] != 2'b10)) begin
                  state_d = S_RD;
               end else begin
                  state_d = S_WR;
               end
            end
         end
         S_RD:   state_d = S_WAIT;
         S_WAIT: begin
            if (we_q) begin
               data_d  = merged;
               state_d = S_WR;
            end else begin
               rdata_d = load_ext;
               state_d = S_RESP;
            end
         end
         S_WR: begin
            rdata_d = 32'b0;
            state_d = S_RESP;
         end
         S_RESP:  state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Strobes and the completion pulse are masked by reset so an aborted access leaves no trace.
   always_comb begin
      req_ready = (state_q == S_IDLE);
      busy      = (state_q != S_IDLE);
      mem_r     = (state_q == S_RD) & ~reset;
      mem_w     = (state_q == S_WR) & ~reset;
      mem_ad    = ((state_q == S_RD) || (state_q == S_WR)) ? idx_q : '0;
      mem_data  = (state_q == S_WR) ? data_q : 32'b0;
      rsp_valid = ((state_q == S_RESP) || (state_q == S_ERR)) & ~reset;
      rsp_err   = (state_q == S_ERR) & ~reset;
      rsp_rdata = rdata_q;
   end

endmodule
